async_rr_merge: RTL and testbench

- Round-robin merge arbiter that shares one downstream pull-style channel (consumer, or an operator's left port) among num_sources upstream pull-style channels (producers, or operator right ports).
- Uses the codebase req/ack convention:
  - The receiver holds req high.
  - The sender answers with a 1-cycle ack pulse, with data valid while ack is high.
- Sits between several dataflow graphs or producers and a single out/consumer port. It serialises their tokens fairly.

---
 rtl/async_rr_merge_pkg.sv | 25 ++
 rtl/async_rr_merge_if.sv | 38 +++
 rtl/async_rr_merge_rr_select.sv | 41 ++++
 rtl/async_rr_merge.sv | 155 +++++++++++++++
 tb/tb_async_rr_merge.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_rr_merge_pkg.sv
// -----------------------------------------------------------------------------
// async_rr_merge_pkg
// Shared types and helpers for the round-robin merge arbiter.
//   state_t : controller state encoding (IDLE=0, FETCH=1, HOLD=2)
//   clog2   : ceiling log2, minimum 1, used to size source indices
// -----------------------------------------------------------------------------
package async_rr_merge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width needed to index n items; never returns less than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/async_rr_merge_if.sv
// -----------------------------------------------------------------------------
// async_rr_merge_if
// Bundles the upstream (src_*) and downstream (dst_*) req/ack channels plus
// the status outputs of the merge arbiter.
//   master : the arbiter side (drives src_req, dst_ack, dst_dout, grant_id, busy)
//   slave  : the environment side (drives src_ack, src_din, src_enable, dst_req)
// src_din packs one data_width slice per source, slice i at
// [data_width*(i+1)-1 : data_width*i].
// -----------------------------------------------------------------------------
interface async_rr_merge_if
    import async_rr_merge_pkg::*;
#(
    parameter int num_sources = 4,
    parameter int data_width  = 32,
    parameter int sel_width   = clog2(num_sources)
);

    logic [num_sources-1:0]            src_req;
    logic [num_sources-1:0]            src_ack;
    logic [data_width*num_sources-1:0] src_din;
    logic [num_sources-1:0]            src_enable;
    logic                              dst_req;
    logic                              dst_ack;
    logic [data_width-1:0]             dst_dout;
    logic [sel_width-1:0]              grant_id;
    logic                              busy;

    modport master (
        output src_req, dst_ack, dst_dout, grant_id, busy,
        input  src_ack, src_din, src_enable, dst_req
    );

    modport slave (
        input  src_req, dst_ack, dst_dout, grant_id, busy,
        output src_ack, src_din, src_enable, dst_req
    );

endinterface

// File: rtl/async_rr_merge_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker: returns the first enabled index found when
// scanning ptr_i, ptr_i+1, ... wrapping at num_sources-1 back to 0.
//   mask_i : eligibility mask, one bit per source
//   ptr_i  : starting index of the scan (always < num_sources)
//   sel_o  : selected index (meaningless when any_o is low)
//   any_o  : at least one mask bit set
// -----------------------------------------------------------------------------
module rr_select
    import async_rr_merge_pkg::*;
#(
    parameter int num_sources = 4,
    parameter int sel_width   = clog2(num_sources)
) (
    input  logic [num_sources-1:0] mask_i,
    input  logic [sel_width-1:0]   ptr_i,
    output logic [sel_width-1:0]   sel_o,
    output logic                   any_o
);

    always_comb begin
        int idx;
        idx   = 0;
        sel_o = ptr_i;
        any_o = |mask_i;
        // Scan from the farthest offset down to offset 0 so the closest
        // enabled index to ptr_i is the last one written and wins.
        for (int k = num_sources - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            // Explicit wrap keeps non-power-of-2 source counts correct.
            if (idx >= num_sources) begin
                idx = idx - num_sources;
            end
            if (mask_i[idx]) begin
                sel_o = sel_width'(idx);
            end
        end
    end

endmodule

// File: rtl/async_rr_merge.sv
// -----------------------------------------------------------------------------
// async_rr_merge
// Round-robin merge arbiter: serialises tokens from num_sources pull-style
// producers onto one pull-style consumer channel. Receivers hold req high,
// senders answer with a single-cycle ack carrying valid data.
//   clk  : system clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : async_rr_merge_if.master
//          src_req/src_ack/src_din/src_enable - upstream channels + mask
//          dst_req/dst_ack/dst_dout           - downstream channel
//          grant_id                           - source currently/last served
//          busy                               - high in FETCH and HOLD
// A token fetched while the consumer has dropped its request is parked in
// HOLD and delivered later, so nothing is lost or duplicated.
// -----------------------------------------------------------------------------
module async_rr_merge
    import async_rr_merge_pkg::*;
#(
    parameter int num_sources = 4,
    parameter int data_width  = 32,
    parameter int sel_width   = clog2(num_sources)
) (
    input  logic             clk,
    input  logic             rst,
    async_rr_merge_if.master bus
);

    state_t                 state_q,    state_d;
    logic [num_sources-1:0] src_req_q,  src_req_d;
    logic                   dst_ack_q,  dst_ack_d;
    logic [data_width-1:0]  dst_dout_q, dst_dout_d;
    logic [data_width-1:0]  buffer_q,   buffer_d;
    logic [sel_width-1:0]   grant_id_q, grant_id_d;
    logic [sel_width-1:0]   rr_ptr_q,   rr_ptr_d;
    logic                   busy_q,     busy_d;

    logic [sel_width-1:0]   sel;
    logic                   any_en;
    logic                   grant_ack;
    logic [data_width-1:0]  grant_data;
    logic [sel_width-1:0]   next_ptr;
    logic [data_width-1:0]  src_slice [num_sources];

    for (genvar g = 0; g < num_sources; g++) begin : g_slice
        assign src_slice[g] = bus.src_din[g*data_width +: data_width];
    end

    rr_select #(
        .num_sources (num_sources),
        .sel_width   (sel_width)
    ) u_rr_select (
        .mask_i (bus.src_enable),
        .ptr_i  (rr_ptr_q),
        .sel_o  (sel),
        .any_o  (any_en)
    );

    // Only the granted source's ack/data matter; everything else is ignored.
    assign grant_ack  = bus.src_ack[grant_id_q];
    assign grant_data = src_slice[grant_id_q];

    // Explicit wrap rather than modulo so non-power-of-2 counts work.
    assign next_ptr = (grant_id_q == sel_width'(num_sources - 1))
                    ? '0 : grant_id_q + sel_width'(1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        src_req_d  = src_req_q;
        dst_ack_d  = 1'b0;
        dst_dout_d = dst_dout_q;
        buffer_d   = buffer_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.dst_req && any_en) begin
                    src_req_d      = '0;
                    src_req_d[sel] = 1'b1;
                    grant_id_d     = sel;
                    busy_d         = 1'b1;
                    state_d        = FETCH;
                end
            end

            FETCH: begin
                // The enable mask is not consulted here: a started fetch
                // always completes.
                if (grant_ack) begin
                    src_req_d = '0;
                    rr_ptr_d  = next_ptr;
                    if (bus.dst_req && !dst_ack_q) begin
                        dst_dout_d = grant_data;
                        dst_ack_d  = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        buffer_d = grant_data;
                        state_d  = HOLD;
                    end
                end
            end

            HOLD: begin
                if (bus.dst_req && !dst_ack_q) begin
                    dst_dout_d = buffer_q;
                    dst_ack_d  = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_req_q  <= '0;
            dst_ack_q  <= 1'b0;
            dst_dout_q <= '0;
            // NOTE: the parking buffer is a plain register, not a memory, so
            // it is reset with everything else; a token held at reset is
            // deliberately discarded.
            buffer_q   <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values, independent of statement order.
            state_q    <= state_d;
            src_req_q  <= src_req_d;
            dst_ack_q  <= dst_ack_d;
            dst_dout_q <= dst_dout_d;
            buffer_q   <= buffer_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.src_req  = src_req_q;
    assign bus.dst_ack  = dst_ack_q;
    assign bus.dst_dout = dst_dout_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_async_rr_merge.sv
// -----------------------------------------------------------------------------
// tb_async_rr_merge
// Self-checking bench for async_rr_merge with three sources. Producers are
// registered responders (ack one cycle after seeing req, optional random
// refusal); every produced token is pushed to a per-source scoreboard queue
// and popped when the consumer side sees dst_ack.
// -----------------------------------------------------------------------------
module tb_async_rr_merge;
    import async_rr_merge_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    async_rr_merge_if #(.num_sources(N), .data_width(DW), .sel_width(SW)) bus ();

    async_rr_merge #(
        .num_sources (N),
        .data_width  (DW),
        .sel_width   (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / bookkeeping ----------------
    logic [DW-1:0] exp_q [N][$];
    int            produced [N];
    int            consumed [N];
    int            consumed_total;
    int            fail_pct;
    int            prod_cnt [N];
    int            cyc = 0;
    int            onehot_viol = 0;
    logic          watch_req1 = 1'b0;
    logic          req1_seen  = 1'b0;

    always @(posedge clk) cyc++;

    // Producers: sample req at the edge, answer 1 time unit later.
    initial begin
        logic [N-1:0] req_s;
        bus.src_ack = '0;
        bus.src_din = '0;
        fail_pct    = 0;
        for (int i = 0; i < N; i++) begin
            prod_cnt[i] = 100 * i;
            produced[i] = 0;
        end
        forever begin
            @(posedge clk);
            req_s = bus.src_req;
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_s[i] === 1'b1 && !bus.src_ack[i] &&
                    ($urandom_range(99) >= 32'(fail_pct))) begin
                    bus.src_ack[i]          = 1'b1;
                    bus.src_din[i*DW +: DW] = DW'(prod_cnt[i]);
                    exp_q[i].push_back(DW'(prod_cnt[i]));
                    prod_cnt[i]++;
                    produced[i]++;
                end else begin
                    bus.src_ack[i] = 1'b0;
                end
            end
        end
    end

    // Consumer-side monitor: pops the scoreboard on each dst_ack.
    initial begin
        logic          prev_ack;
        logic [DW-1:0] exp;
        int            g;
        prev_ack       = 1'b0;
        consumed_total = 0;
        for (int i = 0; i < N; i++) consumed[i] = 0;
        forever begin
            @(negedge clk);
            if (bus.dst_ack === 1'b1) begin
                check("ack_not_back_to_back", prev_ack, 0);
                g = int'(bus.grant_id);
                if (g < N && exp_q[g].size() > 0) begin
                    exp = exp_q[g].pop_front();
                    check("sb_token", bus.dst_dout, exp);
                    consumed[g]++;
                    consumed_total++;
                end else begin
                    total_cnt++;
                    $display("FAIL sb_unexpected: token %0h on grant %0d, expected nothing outstanding",
                             bus.dst_dout, g);
                end
            end
            prev_ack = bus.dst_ack;
            if ($countones(bus.src_req) > 1) onehot_viol++;
            if (watch_req1 && bus.src_req[1] === 1'b1) req1_seen = 1'b1;
        end
    end

    task automatic wait_ack(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.dst_ack !== 1'b1 && n < limit);
        check(name, bus.dst_ack, 1);
    endtask

    typedef struct {
        logic [N-1:0]  en;
        logic [DW-1:0] tok;
        logic [SW-1:0] gid;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int last_cyc;
        int soak_start;
        int cmin, cmax;

        vecs[0] = '{3'b111,   0, 2'd0};
        vecs[1] = '{3'b111, 100, 2'd1};
        vecs[2] = '{3'b111, 200, 2'd2};
        vecs[3] = '{3'b111,   1, 2'd0};
        vecs[4] = '{3'b111, 101, 2'd1};
        vecs[5] = '{3'b111, 201, 2'd2};
        vecs[6] = '{3'b101,   2, 2'd0};
        vecs[7] = '{3'b101, 202, 2'd2};
        vecs[8] = '{3'b101,   3, 2'd0};
        vecs[9] = '{3'b101, 203, 2'd2};

        rst            = 1'b1;
        bus.dst_req    = 1'b0;
        bus.src_enable = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_src_req",  bus.src_req,  0);
        check("rst_dst_ack",  bus.dst_ack,  0);
        check("rst_dst_dout", bus.dst_dout, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_busy",     bus.busy,     0);
        check("rst_state",    dut.state_q,  IDLE);
        check("rst_rr_ptr",   dut.rr_ptr_q, 0);
        rst = 1'b0;

        // Table-driven round-robin: all enabled, then mask 101.
        bus.dst_req = 1'b1;
        last_cyc    = 0;
        for (int r = 0; r < 10; r++) begin
            bus.src_enable = vecs[r].en;
            if (r == 6) watch_req1 = 1'b1;
            wait_ack($sformatf("row%0d_ack", r), 20);
            check($sformatf("row%0d_tok", r),   bus.dst_dout, vecs[r].tok);
            check($sformatf("row%0d_grant", r), bus.grant_id, vecs[r].gid);
            if (r > 0) check($sformatf("row%0d_spacing", r), cyc - last_cyc, 3);
            last_cyc = cyc;
        end
        bus.dst_req = 1'b0;
        watch_req1  = 1'b0;
        check("mask101_no_req1", req1_seen, 0);

        // HOLD: consumer drops request after src_req rises; token 7 parked.
        prod_cnt[0]    = 7;
        bus.src_enable = 3'b101;
        bus.dst_req    = 1'b1;
        @(negedge clk);
        check("hold_req_src0", bus.src_req, 3'b001);
        check("hold_busy_fetch", bus.busy, 1);
        bus.dst_req = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_entered", dut.state_q, HOLD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_state",   dut.state_q, HOLD);
            check("hold_no_req",  bus.src_req, 0);
            check("hold_no_ack",  bus.dst_ack, 0);
            check("hold_busy",    bus.busy,    1);
        end
        bus.dst_req = 1'b1;
        @(negedge clk);
        check("hold_release_ack",  bus.dst_ack,  1);
        check("hold_release_data", bus.dst_dout, 7);
        check("hold_release_idle", dut.state_q,  IDLE);
        bus.dst_req = 1'b0;
        @(negedge clk);
        check("hold_single_ack", bus.dst_ack,  0);
        check("hold_dout_held",  bus.dst_dout, 7);
        check("hold_no_refetch", bus.src_req,  0);

        // All sources disabled: nothing happens, pointer unchanged.
        bus.src_enable = '0;
        bus.dst_req    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("noen_quiet", {bus.src_req, bus.dst_ack}, 0);
        end
        check("noen_ptr", dut.rr_ptr_q, 1);
        bus.src_enable = 3'b100;
        wait_ack("noen_then_src2_ack", 20);
        check("noen_then_src2_grant", bus.grant_id, 2);
        check("noen_then_src2_tok",   bus.dst_dout, 204);
        bus.dst_req = 1'b0;

        // Reset during FETCH.
        bus.src_enable = 3'b111;
        bus.dst_req    = 1'b1;
        wait_ack("prerst_ack", 20);
        check("prerst_tok", bus.dst_dout, 8);
        @(negedge clk);
        check("prerst_fetch_src1", bus.src_req, 3'b010);
        rst = 1'b1;
        @(negedge clk);
        check("rst_fetch_src_req",  bus.src_req,  0);
        check("rst_fetch_dst_ack",  bus.dst_ack,  0);
        check("rst_fetch_grant_id", bus.grant_id, 0);
        check("rst_fetch_busy",     bus.busy,     0);
        rst = 1'b0;
        // The source 1 ack answering the aborted request is discarded.
        for (int i = 0; i < N; i++) exp_q[i].delete();
        wait_ack("postrst_ack", 20);
        check("postrst_grant", bus.grant_id, 0);
        check("postrst_tok",   bus.dst_dout, 9);
        bus.dst_req = 1'b0;
        @(negedge clk);

        // Soak: random refusal on producers and consumer.
        for (int i = 0; i < N; i++) begin
            produced[i] = 0;
            consumed[i] = 0;
        end
        soak_start     = consumed_total;
        fail_pct       = 30;
        bus.src_enable = 3'b111;
        for (int c = 0; c < 60000 && (consumed_total - soak_start) < 5000; c++) begin
            @(negedge clk);
            bus.dst_req = ($urandom_range(99) >= 30);
        end
        check("soak_done_in_budget", (consumed_total - soak_start) >= 5000, 1);
        bus.src_enable = '0;
        bus.dst_req    = 1'b1;
        repeat (80) @(negedge clk);
        check("soak_drained_idle", dut.state_q, IDLE);
        cmin = consumed[0];
        cmax = consumed[0];
        for (int i = 0; i < N; i++) begin
            check($sformatf("soak_q%0d_empty", i), exp_q[i].size(), 0);
            check($sformatf("soak_src%0d_once", i), consumed[i], produced[i]);
            if (consumed[i] < cmin) cmin = consumed[i];
            if (consumed[i] > cmax) cmax = consumed[i];
        end
        check("soak_fairness", (cmax - cmin) <= 1, 1);
        check("src_req_onehot", onehot_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
